// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_stage
//  Description : Instruction-fetch stage in front of the IF/ID register.
//                Owns the PC, keeps at most one fetch in flight on a
//                req/ready + rvalid memory port, and handles downstream
//                stalls and control-flow redirects from EX.
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_stage #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] PC_RST_VAL = '0,
   parameter logic [WIDTH-1:0] INST_NOP   = WIDTH'(32'h0000_0013)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_if,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ready,
   input  logic             imem_rvalid,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic [WIDTH-1:0] instr_if,
   output logic [WIDTH-1:0] pc_if,
   output logic [WIDTH-1:0] pc_plus4_if,
   output logic             if_valid
);

   // FETCH: request on the bus; WAIT: request accepted, awaiting data;
   // HOLD: data captured while IF/ID was stalled.
   localparam logic [1:0] c_st_fetch = 2'd0;
   localparam logic [1:0] c_st_wait  = 2'd1;
   localparam logic [1:0] c_st_hold  = 2'd2;

   localparam logic [WIDTH-1:0] c_pc_step    = WIDTH'(4);
   localparam logic [WIDTH-1:0] c_align_mask = ~(WIDTH'(3));

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_nxt;
   logic [WIDTH-1:0] r_buf;
   logic [WIDTH-1:0] w_buf_nxt;
   logic             r_squash;
   logic             w_squash_nxt;

   logic             w_handshake;
   logic             w_rsp;
   logic [WIDTH-1:0] w_pc_inc;
   logic [WIDTH-1:0] w_redirect_tgt;

   // PC increment wraps naturally modulo 2^WIDTH.
   assign w_pc_inc       = r_pc + c_pc_step;
   assign w_redirect_tgt = redirect_pc & c_align_mask;
   assign w_handshake    = imem_req & imem_ready;
   assign w_rsp          = (r_state == c_st_wait) & imem_rvalid;

   // The address bus always reflects the architectural fetch PC.
   assign imem_addr = r_pc;

   // State register: FSM state, PC, squash flag and the stall buffer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= c_st_fetch;
         r_pc     <= PC_RST_VAL;
         r_squash <= 1'b0;
         r_buf    <= INST_NOP;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_squash <= w_squash_nxt;
         r_buf    <= w_buf_nxt;
      end
   end

   // Next-state logic; a redirect overrides both stall and PC advance.
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_squash_nxt = r_squash;
      w_buf_nxt    = r_buf;

      case (r_state)
         c_st_fetch: begin
            if (w_handshake) begin
               w_state_nxt  = c_st_wait;
               // A request that leaves in the same cycle as a redirect
               // belongs to the old path, so its response is thrown away.
               w_squash_nxt = redirect_valid;
            end
            if (redirect_valid) begin
               w_pc_nxt = w_redirect_tgt;
            end
         end

         c_st_wait: begin
            if (w_rsp) begin
               if (redirect_valid || r_squash) begin
                  w_squash_nxt = 1'b0;
                  w_state_nxt  = c_st_fetch;
                  if (redirect_valid) begin
                     w_pc_nxt = w_redirect_tgt;
                  end
               end else if (!stall_if) begin
                  w_pc_nxt    = w_pc_inc;
                  w_state_nxt = c_st_fetch;
               end else begin
                  w_buf_nxt   = imem_rdata;
                  w_state_nxt = c_st_hold;
               end
            end else if (redirect_valid) begin
               // Response still in flight: remember to drop it.
               w_pc_nxt     = w_redirect_tgt;
               w_squash_nxt = 1'b1;
            end
         end

         c_st_hold: begin
            if (redirect_valid) begin
               w_pc_nxt    = w_redirect_tgt;
               w_state_nxt = c_st_fetch;
            end else if (!stall_if) begin
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = c_st_fetch;
            end
         end

         default: begin
            w_state_nxt  = c_st_fetch;
            w_squash_nxt = 1'b0;
         end
      endcase
   end

   // Output logic; while reset is low every output shows the reset view.
   always_comb begin
      imem_req    = 1'b0;
      if_valid    = 1'b0;
      instr_if    = INST_NOP;
      pc_if       = PC_RST_VAL;
      pc_plus4_if = PC_RST_VAL + c_pc_step;

      if (rst_n) begin
         pc_if       = r_pc;
         pc_plus4_if = w_pc_inc;
         imem_req    = (r_state == c_st_fetch);

         if (!redirect_valid) begin
            if (r_state == c_st_hold) begin
               if_valid = 1'b1;
               instr_if = r_buf;
            end else if (w_rsp && !r_squash) begin
               // Zero-latency pass-through of returning data.
               if_valid = 1'b1;
               instr_if = imem_rdata;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_stage
//  Description : Self-checking bench for if_fetch_stage: directed vector
//                table, reset-wrap sequence and randomized run against a
//                transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_if_fetch_stage;

   localparam logic [31:0] c_nop  = 32'h0000_0013;
   localparam logic [31:0] c_key  = 32'hA5A5_0000;
   localparam logic [31:0] c_wrap = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_if = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;

   // Index 0: default reset PC, index 1: reset PC at the top of memory.
   logic [1:0]  o_req;
   logic [1:0]  o_valid;
   logic [31:0] o_addr  [2];
   logic [31:0] o_instr [2];
   logic [31:0] o_pc    [2];
   logic [31:0] o_pc4   [2];
   logic [31:0] rst_pc  [2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   if_fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .stall_if(stall_if),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(o_req[0]), .imem_addr(o_addr[0]), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_if(o_instr[0]), .pc_if(o_pc[0]), .pc_plus4_if(o_pc4[0]),
      .if_valid(o_valid[0])
   );

   if_fetch_stage #(.PC_RST_VAL(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst_n(rst_n), .stall_if(stall_if),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(o_req[1]), .imem_addr(o_addr[1]), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_if(o_instr[1]), .pc_if(o_pc[1]), .pc_plus4_if(o_pc4[1]),
      .if_valid(o_valid[1])
   );

   typedef struct {
      logic        rn, st, rv;
      logic [31:0] rpc;
      logic        rdy, vld;
      logic [31:0] rd;
      logic        e_req;
      logic [31:0] e_pc;
      logic        e_v;
      logic [31:0] e_instr;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs after the falling edge; outputs settle by return.
   task automatic drive(input logic rn, input logic st, input logic rv, input logic [31:0] rpc,
                        input logic rdy, input logic vld, input logic [31:0] rd);
      @(negedge clk);
      rst_n = rn; stall_if = st; redirect_valid = rv; redirect_pc = rpc;
      imem_ready = rdy; imem_rvalid = vld; imem_rdata = rd;
      #2;
   endtask

   task automatic chk_dut(input int k, input string tag, input logic rn, input logic e_req,
                          input logic [31:0] e_pc, input logic e_v, input logic [31:0] e_instr);
      chk({tag, ".req"},   {31'd0, o_req[k]},   {31'd0, e_req});
      chk({tag, ".valid"}, {31'd0, o_valid[k]}, {31'd0, e_v});
      chk({tag, ".instr"}, o_instr[k], e_instr);
      chk({tag, ".pc"},    o_pc[k],    e_pc);
      chk({tag, ".pc4"},   o_pc4[k],   e_pc + 32'd4);
      if (rn) chk({tag, ".addr"}, o_addr[k], e_pc);
   endtask

   function automatic vec_t mk(input logic rn, input logic st, input logic rv, input logic [31:0] rpc,
                               input logic rdy, input logic vld, input logic [31:0] rd,
                               input logic e_req, input logic [31:0] e_pc, input logic e_v,
                               input logic [31:0] e_instr);
      vec_t v;
      v.rn = rn; v.st = st; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.vld = vld; v.rd = rd;
      v.e_req = e_req; v.e_pc = e_pc; v.e_v = e_v; v.e_instr = e_instr;
      return v;
   endfunction

   // Reference model state: what is in flight, not how the RTL encodes it.
   logic [31:0] m_pc [2];
   bit          m_out, m_sq, m_held;
   logic [31:0] m_hdata, m_reqpc;

   initial begin
      rst_pc[0] = 32'h0;
      rst_pc[1] = c_wrap;

      // ---------------- directed vector table (dut, reset PC 0) ----------------
      //              rn st rv rpc           rdy vld rd                   req pc          v  instr
      tbl.push_back(mk(0, 0, 0, 32'h0,   1, 0, 32'h0,            0, 32'h0,   0, c_nop));
      tbl.push_back(mk(1, 0, 0, 32'h0,   1, 0, 32'h0,            1, 32'h0,   0, c_nop));
      tbl.push_back(mk(1, 0, 0, 32'h0,   0, 1, c_key | 32'h0,    0, 32'h0,   1, c_key | 32'h0));
      tbl.push_back(mk(1, 0, 0, 32'h0,   1, 0, 32'h0,            1, 32'h4,   0, c_nop));
      tbl.push_back(mk(1, 0, 0, 32'h0,   0, 1, c_key | 32'h4,    0, 32'h4,   1, c_key | 32'h4));
      tbl.push_back(mk(1, 0, 0, 32'h0,   1, 0, 32'h0,            1, 32'h8,   0, c_nop));
      tbl.push_back(mk(1, 1, 0, 32'h0,   0, 1, c_key | 32'h8,    0, 32'h8,   1, c_key | 32'h8));
      tbl.push_back(mk(1, 1, 0, 32'h0,   0, 0, 32'h0,            0, 32'h8,   1, c_key | 32'h8));
      tbl.push_back(mk(1, 1, 0, 32'h0,   0, 0, 32'h0,            0, 32'h8,   1, c_key | 32'h8));
      tbl.push_back(mk(1, 0, 0, 32'h0,   0, 0, 32'h0,            0, 32'h8,   1, c_key | 32'h8));
      tbl.push_back(mk(1, 0, 0, 32'h0,   0, 0, 32'h0,            1, 32'hC,   0, c_nop));
      tbl.push_back(mk(1, 0, 0, 32'h0,   1, 0, 32'h0,            1, 32'hC,   0, c_nop));
      tbl.push_back(mk(1, 0, 0, 32'h0,   0, 1, c_key | 32'hC,    0, 32'hC,   1, c_key | 32'hC));
      tbl.push_back(mk(1, 0, 1, 32'h103, 1, 0, 32'h0,            1, 32'h10,  0, c_nop));
      tbl.push_back(mk(1, 0, 0, 32'h0,   0, 1, c_key | 32'h10,   0, 32'h100, 0, c_nop));
      tbl.push_back(mk(1, 0, 0, 32'h0,   1, 0, 32'h0,            1, 32'h100, 0, c_nop));
      tbl.push_back(mk(1, 0, 0, 32'h0,   0, 1, c_key | 32'h100,  0, 32'h100, 1, c_key | 32'h100));
      tbl.push_back(mk(1, 0, 0, 32'h0,   1, 0, 32'h0,            1, 32'h104, 0, c_nop));
      tbl.push_back(mk(1, 1, 0, 32'h0,   0, 1, c_key | 32'h104,  0, 32'h104, 1, c_key | 32'h104));
      tbl.push_back(mk(1, 1, 1, 32'h200, 0, 0, 32'h0,            0, 32'h104, 0, c_nop));
      tbl.push_back(mk(1, 1, 0, 32'h0,   0, 0, 32'h0,            1, 32'h200, 0, c_nop));
      tbl.push_back(mk(1, 1, 0, 32'h0,   0, 0, 32'h0,            1, 32'h200, 0, c_nop));
      tbl.push_back(mk(1, 0, 0, 32'h0,   0, 0, 32'h0,            1, 32'h200, 0, c_nop));
      tbl.push_back(mk(1, 0, 0, 32'h0,   0, 0, 32'h0,            1, 32'h200, 0, c_nop));
      tbl.push_back(mk(1, 0, 0, 32'h0,   0, 0, 32'h0,            1, 32'h200, 0, c_nop));
      tbl.push_back(mk(1, 0, 0, 32'h0,   1, 0, 32'h0,            1, 32'h200, 0, c_nop));

      foreach (tbl[i]) begin
         drive(tbl[i].rn, tbl[i].st, tbl[i].rv, tbl[i].rpc, tbl[i].rdy, tbl[i].vld, tbl[i].rd);
         chk_dut(0, $sformatf("vec%0d", i), tbl[i].rn, tbl[i].e_req, tbl[i].e_pc,
                 tbl[i].e_v, tbl[i].e_instr);
      end

      // ---------------- reset PC at top of memory, reset during WAIT ----------------
      drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
      chk_dut(1, "wrap.rst", 0, 0, c_wrap, 0, c_nop);
      drive(1, 0, 0, 32'h0, 1, 0, 32'h0);
      chk_dut(1, "wrap.fetch", 1, 1, c_wrap, 0, c_nop);
      drive(1, 0, 0, 32'h0, 0, 1, 32'h1234_5678);
      chk_dut(1, "wrap.data", 1, 0, c_wrap, 1, 32'h1234_5678);
      drive(1, 0, 0, 32'h0, 1, 0, 32'h0);
      chk_dut(1, "wrap.next", 1, 1, 32'h0, 0, c_nop);
      drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
      chk_dut(1, "wrap.rst_wait", 0, 0, c_wrap, 0, c_nop);
      drive(1, 0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
      chk_dut(1, "wrap.stale", 1, 1, c_wrap, 0, c_nop);
      drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
      chk_dut(1, "wrap.idle", 1, 1, c_wrap, 0, c_nop);

      // ---------------- randomized run against reference model ----------------
      m_out = 0; m_sq = 0; m_held = 0; m_hdata = c_nop; m_reqpc = '0;
      m_pc[0] = rst_pc[0]; m_pc[1] = rst_pc[1];
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        rn, st, rv, rdy, vld, e_req, e_v, hs, rsp, inflight;
         logic [31:0] rpc, rd;
         logic [31:0] e_instr;
         rn  = (cyc < 2) ? 1'b0 : ($urandom_range(0, 59) != 0);
         st  = ($urandom_range(0, 2) == 0);
         rv  = ($urandom_range(0, 9) == 0);
         rpc = $urandom;
         rdy = ($urandom_range(0, 3) != 0);
         if (!rn)        vld = $urandom_range(0, 1) == 1;
         else if (m_out) vld = ($urandom_range(0, 2) != 0);
         else            vld = !m_held && ($urandom_range(0, 7) == 0);
         rd  = m_out ? (m_reqpc ^ c_key) : $urandom;

         drive(rn, st, rv, rpc, rdy, vld, rd);

         if (!rn) begin
            e_req = 0; e_v = 0; e_instr = c_nop;
         end else begin
            e_req   = !m_out && !m_held;
            e_v     = !rv && ((m_out && vld && !m_sq) || m_held);
            e_instr = e_v ? (m_held ? m_hdata : rd) : c_nop;
         end
         for (int k = 0; k < 2; k++) begin
            chk_dut(k, $sformatf("rnd%0d.d%0d", cyc, k), rn, e_req,
                    rn ? m_pc[k] : rst_pc[k], e_v, e_instr);
         end

         if (!rn) begin
            m_pc[0] = rst_pc[0]; m_pc[1] = rst_pc[1];
            m_out = 0; m_sq = 0; m_held = 0;
         end else begin
            hs       = e_req && rdy;
            rsp      = m_out && vld;
            inflight = (m_out && !vld) || hs;
            if (hs) m_reqpc = m_pc[0];
            if (rv) begin
               for (int k = 0; k < 2; k++) m_pc[k] = rpc & ~32'd3;
               m_sq   = inflight;
               m_held = 0;
            end else begin
               if (rsp && !m_sq) begin
                  if (st) begin
                     m_held  = 1;
                     m_hdata = rd;
                  end else begin
                     for (int k = 0; k < 2; k++) m_pc[k] = m_pc[k] + 32'd4;
                  end
               end else if (m_held && !st) begin
                  m_held = 0;
                  for (int k = 0; k < 2; k++) m_pc[k] = m_pc[k] + 32'd4;
               end
               if (rsp) m_sq = 0;
            end
            m_out = inflight;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
